// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: types and constants shared across the RV32I pipeline stages.
//   ALU_OP_W / REG_IDX_W : field widths
//   alu_op_e             : ALU operation encodings
//   ctrl_t               : per-instruction control bundle carried down the pipe
//   CTRL_BUBBLE          : control value of an inserted bubble (no side effects)
package riscv_pipe_pkg;

   localparam int ALU_OP_W  = 4;
   localparam int REG_IDX_W = 5;

   typedef enum logic [ALU_OP_W-1:0] {
      ALU_ADD    = 4'd0,
      ALU_SUB    = 4'd1,
      ALU_SLL    = 4'd2,
      ALU_SLT    = 4'd3,
      ALU_SLTU   = 4'd4,
      ALU_XOR    = 4'd5,
      ALU_SRL    = 4'd6,
      ALU_SRA    = 4'd7,
      ALU_OR     = 4'd8,
      ALU_AND    = 4'd9,
      ALU_PASS_B = 4'd10
   } alu_op_e;

   typedef struct packed {
      logic                reg_write;
      logic                mem_read;
      logic                mem_write;
      logic                mem_to_reg;
      logic                alu_src;
      logic                is_halt;
      logic [ALU_OP_W-1:0] alu_op;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/load_use_detector.sv
// load_use_detector: flags an instruction in ID that reads the destination of
// a load currently in EX. Purely combinational; also used by the formal
// hazard checker.
//   ex_valid, ex_mem_read, ex_rd        : instruction in EX
//   id_valid, id_rs1/2, id_use_rs1/2    : instruction in ID and which sources it reads
//   load_use                            : hazard present this cycle
import riscv_pipe_pkg::*;

module load_use_detector (
   input  logic                 ex_valid,
   input  logic                 ex_mem_read,
   input  logic [REG_IDX_W-1:0] ex_rd,
   input  logic                 id_valid,
   input  logic                 id_use_rs1,
   input  logic                 id_use_rs2,
   input  logic [REG_IDX_W-1:0] id_rs1,
   input  logic [REG_IDX_W-1:0] id_rs2,
   output logic                 load_use
);

   logic ex_is_load;
   logic rs1_hit;
   logic rs2_hit;

   always_comb begin
      // A load to x0 never produces a value anyone can depend on.
      ex_is_load = ex_valid && ex_mem_read && (ex_rd != '0);
      rs1_hit    = id_use_rs1 && (id_rs1 == ex_rd);
      rs2_hit    = id_use_rs2 && (id_rs2 == ex_rd);
      load_use   = ex_is_load && id_valid && (rs1_hit || rs2_hit);
   end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall and flush bubbles.
//   clk, reset_n                 : core clock, async active-low reset
//   id_*                         : decoded instruction from ID
//   ex_flush                     : EX resolved a taken/mispredicted transfer
//   ex_*                         : registered instruction presented to EX
//   pc_write, if_id_write        : 0 holds PC and IF/ID (load-use stall)
//   stall_cnt, flush_cnt         : saturating event counters for perf CSRs
import riscv_pipe_pkg::*;

module id_ex_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic                 clk,
   input  logic                 reset_n,

   input  logic                 id_valid,
   input  logic [XLEN-1:0]      id_pc,
   input  logic [REG_IDX_W-1:0] id_rs1,
   input  logic [REG_IDX_W-1:0] id_rs2,
   input  logic [REG_IDX_W-1:0] id_rd,
   input  logic                 id_use_rs1,
   input  logic                 id_use_rs2,
   input  logic [XLEN-1:0]      id_rs1_data,
   input  logic [XLEN-1:0]      id_rs2_data,
   input  logic [XLEN-1:0]      id_imm,
   input  logic                 id_reg_write,
   input  logic                 id_mem_read,
   input  logic                 id_mem_write,
   input  logic                 id_mem_to_reg,
   input  logic                 id_alu_src,
   input  logic                 id_is_halt,
   input  logic [ALU_OP_W-1:0]  id_alu_op,

   input  logic                 ex_flush,

   output logic                 ex_valid,
   output logic [XLEN-1:0]      ex_pc,
   output logic [REG_IDX_W-1:0] ex_rs1,
   output logic [REG_IDX_W-1:0] ex_rs2,
   output logic [REG_IDX_W-1:0] ex_rd,
   output logic [XLEN-1:0]      ex_rs1_data,
   output logic [XLEN-1:0]      ex_rs2_data,
   output logic [XLEN-1:0]      ex_imm,
   output logic                 ex_reg_write,
   output logic                 ex_mem_read,
   output logic                 ex_mem_write,
   output logic                 ex_mem_to_reg,
   output logic                 ex_alu_src,
   output logic                 ex_is_halt,
   output logic [ALU_OP_W-1:0]  ex_alu_op,

   output logic                 pc_write,
   output logic                 if_id_write,
   output logic [CNT_W-1:0]     stall_cnt,
   output logic [CNT_W-1:0]     flush_cnt
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                input logic             en);
      if (en && (v != '1))
         return v + {{(CNT_W-1){1'b0}}, 1'b1};
      return v;
   endfunction

   logic                 valid_d,     valid_q;
   logic [XLEN-1:0]      pc_d,        pc_q;
   logic [REG_IDX_W-1:0] rs1_d,       rs1_q;
   logic [REG_IDX_W-1:0] rs2_d,       rs2_q;
   logic [REG_IDX_W-1:0] rd_d,        rd_q;
   logic [XLEN-1:0]      rs1_data_d,  rs1_data_q;
   logic [XLEN-1:0]      rs2_data_d,  rs2_data_q;
   logic [XLEN-1:0]      imm_d,       imm_q;
   ctrl_t                ctrl_d,      ctrl_q;
   logic [CNT_W-1:0]     stall_cnt_d, stall_cnt_q;
   logic [CNT_W-1:0]     flush_cnt_d, flush_cnt_q;

   ctrl_t id_ctrl;
   logic  load_use;
   logic  stall;
   logic  bubble;

   load_use_detector u_load_use_detector (
      .ex_valid    (valid_q),
      .ex_mem_read (ctrl_q.mem_read),
      .ex_rd       (rd_q),
      .id_valid    (id_valid),
      .id_use_rs1  (id_use_rs1),
      .id_use_rs2  (id_use_rs2),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .load_use    (load_use)
   );

   // The flush squashes the ID instruction anyway, so holding the front end
   // for it would only waste a cycle.
   assign stall       = load_use && !ex_flush;
   assign bubble      = ex_flush || stall;
   assign pc_write    = !stall;
   assign if_id_write = !stall;

   always_comb begin
      id_ctrl = '{reg_write:  id_reg_write,
                  mem_read:   id_mem_read,
                  mem_write:  id_mem_write,
                  mem_to_reg: id_mem_to_reg,
                  alu_src:    id_alu_src,
                  is_halt:    id_is_halt,
                  alu_op:     id_alu_op};

      valid_d    = id_valid;
      pc_d       = id_pc;
      rs1_d      = id_rs1;
      rs2_d      = id_rs2;
      rd_d       = id_rd;
      rs1_data_d = id_rs1_data;
      rs2_data_d = id_rs2_data;
      imm_d      = id_imm;
      ctrl_d     = id_valid ? id_ctrl : CTRL_BUBBLE;

      // Bubble zeroes indices too, so forwarding sees rd = 0 and never matches.
      if (bubble) begin
         valid_d    = 1'b0;
         pc_d       = '0;
         rs1_d      = '0;
         rs2_d      = '0;
         rd_d       = '0;
         rs1_data_d = '0;
         rs2_data_d = '0;
         imm_d      = '0;
         ctrl_d     = CTRL_BUBBLE;
      end

      stall_cnt_d = sat_inc(stall_cnt_q, stall);
      flush_cnt_d = sat_inc(flush_cnt_q, ex_flush && id_valid);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q     <= 1'b0;
         pc_q        <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         rd_q        <= '0;
         rs1_data_q  <= '0;
         rs2_data_q  <= '0;
         imm_q       <= '0;
         ctrl_q      <= CTRL_BUBBLE;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         valid_q     <= valid_d;
         pc_q        <= pc_d;
         rs1_q       <= rs1_d;
         rs2_q       <= rs2_d;
         rd_q        <= rd_d;
         rs1_data_q  <= rs1_data_d;
         rs2_data_q  <= rs2_data_d;
         imm_q       <= imm_d;
         ctrl_q      <= ctrl_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign ex_valid      = valid_q;
   assign ex_pc         = pc_q;
   assign ex_rs1        = rs1_q;
   assign ex_rs2        = rs2_q;
   assign ex_rd         = rd_q;
   assign ex_rs1_data   = rs1_data_q;
   assign ex_rs2_data   = rs2_data_q;
   assign ex_imm        = imm_q;
   assign ex_reg_write  = ctrl_q.reg_write;
   assign ex_mem_read   = ctrl_q.mem_read;
   assign ex_mem_write  = ctrl_q.mem_write;
   assign ex_mem_to_reg = ctrl_q.mem_to_reg;
   assign ex_alu_src    = ctrl_q.alu_src;
   assign ex_is_halt    = ctrl_q.is_halt;
   assign ex_alu_op     = ctrl_q.alu_op;
   assign stall_cnt     = stall_cnt_q;
   assign flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vectors for id_ex_stage. The stimulus process pushes
// the expected EX-side state for each cycle into a queue; a monitor pops one
// entry after each clock edge and compares it with the registered outputs.
// Counters are built 4 bits wide so saturation is reachable quickly.
module tb_id_ex_stage;
   import riscv_pipe_pkg::*;

   localparam int XLEN  = 32;
   localparam int CNT_W = 4;

   logic                 clk = 1'b0;
   logic                 reset_n = 1'b1;
   logic                 id_valid, id_use_rs1, id_use_rs2;
   logic [XLEN-1:0]      id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [REG_IDX_W-1:0] id_rs1, id_rs2, id_rd;
   logic                 id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
   logic                 id_alu_src, id_is_halt;
   logic [ALU_OP_W-1:0]  id_alu_op;
   logic                 ex_flush;
   logic                 ex_valid;
   logic [XLEN-1:0]      ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [REG_IDX_W-1:0] ex_rs1, ex_rs2, ex_rd;
   logic                 ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
   logic                 ex_alu_src, ex_is_halt;
   logic [ALU_OP_W-1:0]  ex_alu_op;
   logic                 pc_write, if_id_write;
   logic [CNT_W-1:0]     stall_cnt, flush_cnt;

   always #5 clk = ~clk;

   id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset_n(reset_n),
      .id_valid(id_valid), .id_pc(id_pc),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
      .id_alu_src(id_alu_src), .id_is_halt(id_is_halt), .id_alu_op(id_alu_op),
      .ex_flush(ex_flush),
      .ex_valid(ex_valid), .ex_pc(ex_pc),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
      .ex_alu_src(ex_alu_src), .ex_is_halt(ex_is_halt), .ex_alu_op(ex_alu_op),
      .pc_write(pc_write), .if_id_write(if_id_write),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   typedef struct packed {
      logic        v;
      logic [31:0] pc;
      logic [4:0]  rs1, rs2, rd;
      logic        u1, u2;
      logic [31:0] d1, d2, imm;
      logic        rw, mr, mw, m2r, as, halt;
      logic [3:0]  op;
      logic        flush;
   } vin_t;

   typedef struct packed {
      logic        v;
      logic [31:0] pc;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] d1, d2, imm;
      logic        rw, mr, mw, m2r, as, halt;
      logic [3:0]  op;
      logic [3:0]  sc, fc;
   } exp_t;

   exp_t             sb_q[$];
   int               checks = 0;
   int               failures = 0;
   logic [CNT_W-1:0] sc_m = '0;
   logic [CNT_W-1:0] fc_m = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] v);
      if (v == '1) return v;
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   // Builds an instruction; loads set mem_read/mem_to_reg/alu_src.
   function automatic vin_t ins(input logic [31:0] pc, input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                                input logic ld);
      vin_t i = '0;
      i.v   = 1'b1;
      i.pc  = pc;
      i.rs1 = rs1;  i.u1 = u1;
      i.rs2 = rs2;  i.u2 = u2;
      i.rd  = rd;
      i.d1  = pc ^ 32'hA5A5_0000;
      i.d2  = pc + 32'd7;
      i.imm = {2'b00, pc[31:2]};
      i.rw  = 1'b1;
      i.mr  = ld;  i.m2r = ld;  i.as = ld;
      i.op  = ld ? 4'd0 : pc[5:2];
      return i;
   endfunction

   function automatic exp_t cap(input vin_t i);
      exp_t e = '0;
      e.v = i.v;  e.pc = i.pc;
      e.rs1 = i.rs1;  e.rs2 = i.rs2;  e.rd = i.rd;
      e.d1 = i.d1;  e.d2 = i.d2;  e.imm = i.imm;
      if (i.v) begin
         e.rw = i.rw;  e.mr = i.mr;  e.mw = i.mw;  e.m2r = i.m2r;
         e.as = i.as;  e.halt = i.halt;  e.op = i.op;
      end
      return e;
   endfunction

   task automatic apply(input vin_t i);
      id_valid = i.v;  id_pc = i.pc;
      id_rs1 = i.rs1;  id_rs2 = i.rs2;  id_rd = i.rd;
      id_use_rs1 = i.u1;  id_use_rs2 = i.u2;
      id_rs1_data = i.d1;  id_rs2_data = i.d2;  id_imm = i.imm;
      id_reg_write = i.rw;  id_mem_read = i.mr;  id_mem_write = i.mw;
      id_mem_to_reg = i.m2r;  id_alu_src = i.as;  id_is_halt = i.halt;
      id_alu_op = i.op;  ex_flush = i.flush;
   endtask

   // Called 2 time units after a rising edge; returns at the same phase one
   // cycle later. exp_pcw is the hand-determined pc_write for this cycle.
   task automatic cyc(input vin_t i, input logic exp_pcw);
      exp_t e;
      apply(i);
      if (!exp_pcw) sc_m = sat(sc_m);
      if (i.flush && i.v) fc_m = sat(fc_m);
      if (exp_pcw && !i.flush) e = cap(i);
      else e = '0;
      e.sc = sc_m;
      e.fc = fc_m;
      sb_q.push_back(e);
      #3;
      chk("pc_write", 64'(pc_write), 64'(exp_pcw));
      chk("if_id_write", 64'(if_id_write), 64'(exp_pcw));
      @(posedge clk);
      #2;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_ex_valid"}, 64'(ex_valid), 64'd0);
      chk({tag, "_ex_pc"}, 64'(ex_pc), 64'd0);
      chk({tag, "_ex_idx"}, 64'({ex_rs1, ex_rs2, ex_rd}), 64'd0);
      chk({tag, "_ex_data"}, 64'(ex_rs1_data | ex_rs2_data | ex_imm), 64'd0);
      chk({tag, "_ex_ctrl"}, 64'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
                                  ex_alu_src, ex_is_halt, ex_alu_op}), 64'd0);
      chk({tag, "_pc_write"}, 64'(pc_write), 64'd1);
      chk({tag, "_if_id_write"}, 64'(if_id_write), 64'd1);
      chk({tag, "_stall_cnt"}, 64'(stall_cnt), 64'd0);
      chk({tag, "_flush_cnt"}, 64'(flush_cnt), 64'd0);
   endtask

   // Monitor: one expected entry per registered cycle.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("ex_valid", 64'(ex_valid), 64'(e.v));
            chk("ex_pc", 64'(ex_pc), 64'(e.pc));
            chk("ex_rs1", 64'(ex_rs1), 64'(e.rs1));
            chk("ex_rs2", 64'(ex_rs2), 64'(e.rs2));
            chk("ex_rd", 64'(ex_rd), 64'(e.rd));
            chk("ex_rs1_data", 64'(ex_rs1_data), 64'(e.d1));
            chk("ex_rs2_data", 64'(ex_rs2_data), 64'(e.d2));
            chk("ex_imm", 64'(ex_imm), 64'(e.imm));
            chk("ex_reg_write", 64'(ex_reg_write), 64'(e.rw));
            chk("ex_mem_read", 64'(ex_mem_read), 64'(e.mr));
            chk("ex_mem_write", 64'(ex_mem_write), 64'(e.mw));
            chk("ex_mem_to_reg", 64'(ex_mem_to_reg), 64'(e.m2r));
            chk("ex_alu_src", 64'(ex_alu_src), 64'(e.as));
            chk("ex_is_halt", 64'(ex_is_halt), 64'(e.halt));
            chk("ex_alu_op", 64'(ex_alu_op), 64'(e.op));
            chk("stall_cnt", 64'(stall_cnt), 64'(e.sc));
            chk("flush_cnt", 64'(flush_cnt), 64'(e.fc));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vin_t i;
      i = '0;
      apply(i);
      #1 reset_n = 1'b0;
      #1 chk_reset("por");
      repeat (2) @(posedge clk);
      #2 reset_n = 1'b1;

      // Plain capture.
      i = ins(32'h100, 5'd1, 1, 5'd2, 1, 5'd5, 0);
      i.d1 = 32'h1234;
      cyc(i, 1);

      // lw x5, then add x6,x5,x7: one stall, then the re-presented add goes.
      i = ins(32'h104, 5'd2, 1, 5'd0, 0, 5'd5, 1);
      cyc(i, 1);
      i = ins(32'h108, 5'd5, 1, 5'd7, 1, 5'd6, 0);
      cyc(i, 0);
      cyc(i, 1);
      chk("ldu_ex_rs1", 64'(ex_rs1), 64'd5);
      chk("ldu_ex_valid", 64'(ex_valid), 64'd1);
      chk("ldu_stall_cnt", 64'(stall_cnt), 64'd1);

      // lw x0 then a reader of x0: no stall.
      i = ins(32'h10c, 5'd0, 0, 5'd0, 0, 5'd0, 1);
      cyc(i, 1);
      i = ins(32'h110, 5'd0, 1, 5'd0, 1, 5'd8, 0);
      cyc(i, 1);

      // lw x5 then id_rs2 = 5 with use_rs2 = 0: no stall.
      i = ins(32'h114, 5'd3, 1, 5'd0, 0, 5'd5, 1);
      cyc(i, 1);
      i = ins(32'h118, 5'd3, 1, 5'd5, 0, 5'd9, 0);
      cyc(i, 1);

      // Flush beats stall.
      i = ins(32'h11c, 5'd3, 1, 5'd0, 0, 5'd5, 1);
      cyc(i, 1);
      i = ins(32'h120, 5'd5, 1, 5'd0, 0, 5'd10, 0);
      i.flush = 1'b1;
      cyc(i, 1);
      chk("flush_cnt_one", 64'(flush_cnt), 64'd1);
      chk("flush_stall_cnt", 64'(stall_cnt), 64'd1);

      // id_valid = 0: data captured, control forced to 0.
      i = ins(32'h200, 5'd12, 1, 5'd13, 1, 5'd12, 1);
      i.v = 1'b0;  i.halt = 1'b1;  i.mw = 1'b1;  i.op = 4'd5;
      cyc(i, 1);

      // Flush with id_valid = 0: bubble, flush_cnt unchanged.
      i = ins(32'h204, 5'd1, 1, 5'd2, 1, 5'd3, 0);
      i.v = 1'b0;  i.flush = 1'b1;
      cyc(i, 1);

      // Back-to-back loads, each dependency stalls once.
      i = ins(32'h300, 5'd1, 1, 5'd0, 0, 5'd5, 1);
      cyc(i, 1);
      i = ins(32'h304, 5'd5, 1, 5'd0, 0, 5'd6, 1);
      cyc(i, 0);
      cyc(i, 1);
      i = ins(32'h308, 5'd6, 1, 5'd5, 1, 5'd7, 0);
      cyc(i, 0);
      cyc(i, 1);
      chk("b2b_stall_cnt", 64'(stall_cnt), 64'd3);

      // Drive stall_cnt into saturation (4-bit counter).
      for (int k = 0; k < 14; k++) begin
         i = ins(32'h400 + 32'(k * 8), 5'd1, 1, 5'd0, 0, 5'd5, 1);
         cyc(i, 1);
         i = ins(32'h404 + 32'(k * 8), 5'd0, 0, 5'd5, 1, 5'd6, 0);
         cyc(i, 0);
      end
      chk("stall_cnt_sat", 64'(stall_cnt), 64'hF);

      // Reset asserted during a stall cycle.
      i = ins(32'h500, 5'd1, 1, 5'd0, 0, 5'd5, 1);
      cyc(i, 1);
      i = ins(32'h504, 5'd5, 1, 5'd0, 0, 5'd6, 0);
      apply(i);
      #3;
      chk("mid_stall_pc_write", 64'(pc_write), 64'd0);
      reset_n = 1'b0;
      #1;
      chk_reset("mid");
      sc_m = '0;
      fc_m = '0;
      @(posedge clk);
      #2 reset_n = 1'b1;
      cyc(i, 1);
      i = ins(32'h508, 5'd0, 0, 5'd0, 0, 5'd0, 0);
      cyc(i, 1);

      for (int k = 0; k < 20 && sb_q.size() > 0; k++) @(posedge clk);
      #3;
      chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
